// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle arithmetic/logic ops and iterative one-bit-per-clock
// shifts, with valid/ready handshakes on request and result.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             overflow,
  output logic             carry,
  output logic             zero,
  output logic             negative
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] LP_NMAX = WIDTH'(WIDTH - 1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_y, w_y_next;
  logic             r_ovf, w_ovf_next;
  logic             r_carry, w_carry_next;
  logic [CW-1:0]    r_cnt, w_cnt_next;
  logic [1:0]       r_sh, w_sh_next;

  logic             w_accept;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_diff;
  logic [CW-1:0]    w_n;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_sum    = {1'b0, a} + {1'b0, b};
  assign w_diff   = {1'b0, a} - {1'b0, b};
  // Shift amounts at or beyond the word width saturate to WIDTH-1.
  assign w_n      = (b > LP_NMAX) ? LP_NMAX[CW-1:0] : b[CW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_y     <= '0;
      r_ovf   <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sh    <= 2'b00;
    end else begin
      r_state <= w_state_next;
      r_y     <= w_y_next;
      r_ovf   <= w_ovf_next;
      r_carry <= w_carry_next;
      r_cnt   <= w_cnt_next;
      r_sh    <= w_sh_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_y_next     = r_y;
    w_ovf_next   = r_ovf;
    w_carry_next = r_carry;
    w_cnt_next   = r_cnt;
    w_sh_next    = r_sh;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_ovf_next   = 1'b0;
          w_carry_next = 1'b0;
          w_state_next = S_DONE;
          case (op)
            3'b000: begin
              w_y_next     = w_sum[WIDTH-1:0];
              w_carry_next = w_sum[WIDTH];
              w_ovf_next   = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
            end
            3'b001: begin
              w_y_next     = w_diff[WIDTH-1:0];
              w_carry_next = w_diff[WIDTH];
              w_ovf_next   = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
            end
            3'b010:  w_y_next = a & b;
            3'b011:  w_y_next = a | b;
            3'b100:  w_y_next = a ^ b;
            default: begin
              // Shifts: load operand, then walk one bit per clock in SHIFT.
              w_y_next   = a;
              w_sh_next  = op[1:0];
              w_cnt_next = w_n;
              if (w_n != '0) w_state_next = S_SHIFT;
            end
          endcase
        end
      end
      S_SHIFT: begin
        case (r_sh)
          2'b01:   w_y_next = {r_y[WIDTH-2:0], 1'b0};
          2'b10:   w_y_next = {1'b0, r_y[WIDTH-1:1]};
          default: w_y_next = {r_y[WIDTH-1], r_y[WIDTH-1:1]};
        endcase
        w_cnt_next = r_cnt - CW'(1);
        if (r_cnt <= CW'(1)) begin
          w_cnt_next   = '0;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign y         = r_y;
  assign overflow  = r_ovf;
  assign carry     = r_carry;
  assign zero      = (r_y == '0);
  assign negative  = r_y[WIDTH-1];

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
- REQ-001 SHALL have parameter WIDTH, default 8; operand and result width in bits, WIDTH >= 2.
- REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
- REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
- REQ-004 SHALL have port in_valid  input  1  request present.
- REQ-005 SHALL have port in_ready  output  1  block can accept a request.
- REQ-006 SHALL have port a  input  WIDTH  operand A.
- REQ-007 SHALL have port b  input  WIDTH  operand B, or shift amount for shift ops.
- REQ-008 SHALL have port op  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA.
- REQ-009 SHALL have port out_valid  output  1  result present.
- REQ-010 SHALL have port out_ready  input  1  consumer takes result.
- REQ-011 SHALL have port y  output  WIDTH  result.
- REQ-012 SHALL have ports overflow, carry, zero, negative  output  1 each  result flags.

Function
- REQ-013 SHALL implement states IDLE, SHIFT, DONE.
- REQ-014 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only.
- REQ-015 Accept condition: in_valid && in_ready; a, b and op SHALL be captured on the accepting edge, and later input changes SHALL have no effect.
- REQ-016 ADD/SUB/AND/OR/XOR SHALL go IDLE->DONE on accept, so out_valid is high on the cycle after accept (latency 1).
- REQ-017 ADD: y = (a+b) mod 2^WIDTH; carry = bit WIDTH of {0,a}+{0,b}; overflow = (a[MSB]==b[MSB]) && (y[MSB]!=a[MSB]).
- REQ-018 SUB: y = (a-b) mod 2^WIDTH; carry = bit WIDTH of {0,a}-{0,b} (borrow, 1 iff a<b unsigned); overflow = (a[MSB]!=b[MSB]) && (y[MSB]!=a[MSB]).
- REQ-019 AND/OR/XOR and all shifts SHALL drive overflow=0 and carry=0.
- REQ-020 Shift count n SHALL be b when b < WIDTH, else WIDTH-1 (saturating clamp).
- REQ-021 Shifts SHALL be iterative, one bit position per clock: SLL fills with 0, SRL fills with 0, SRA replicates the MSB.
- REQ-022 A shift with n=0 SHALL go IDLE->DONE with y=a (latency 1); with n>0 it SHALL go IDLE->SHIFT, remain in SHIFT n cycles, then go to DONE (out_valid high n+1 cycles after accept).
- REQ-023 zero SHALL be (y==0), and negative SHALL be y[WIDTH-1], for every op.
- REQ-024 In DONE, y and all flags SHALL stay stable until out_valid && out_ready; on that edge the block SHALL go to IDLE.
- REQ-025 A new request SHALL not be accepted on the same edge as result handoff; back-to-back single-cycle ops therefore complete at most one per 2 cycles.
- REQ-026 y and the flags SHALL be registered outputs; no combinational path SHALL exist from a, b or op to y or the flags.
- REQ-027 Undefined behaviour is forbidden: every opcode value is defined, and the state register SHALL recover to IDLE from any illegal encoding.

Reset
- REQ-028 When rst_n is low: state = IDLE, in_ready = 1, out_valid = 0, y = 0, overflow = carry = negative = 0, zero = 1, shift counter = 0.
- REQ-029 Reset asserted mid-SHIFT or in DONE SHALL abort the operation immediately and discard the pending result.
- REQ-030 After rst_n deasserts, the first request SHALL be accepted on the first rising edge at which in_valid=1.

Verification (WIDTH=8)
- REQ-031 ADD a=0x7F, b=0x01 -> one cycle after accept: y=0x80, overflow=1, carry=0, negative=1, zero=0.
- REQ-032 SUB a=0x00, b=0x01 -> y=0xFF, carry=1, overflow=0, negative=1; then SUB a=0x05, b=0x05 -> y=0x00, zero=1, carry=0.
- REQ-033 SRA a=0x80, b=9 -> clamp n=7, out_valid 8 cycles after accept, y=0xFF; SLL a=0x3C, b=0 -> y=0x3C at latency 1.
- REQ-034 XOR a=0xAA, b=0xFF with out_ready held low 3 cycles -> y=0x55, and out_valid, y and flags stay stable; in_ready=0 throughout; handoff occurs on the first cycle with out_ready=1.
- REQ-035 SRL a=0xF0, b=4 with rst_n pulsed low on the 2nd SHIFT cycle -> out_valid=0, y=0, zero=1 immediately; no result appears afterward; the next request completes normally.
- REQ-036 Randomized op/a/b stream with random out_ready, compared against the golden model in REQ-017..REQ-023 -> zero mismatches; accepted-request count equals handed-off-result count.
